frecomp_rot_ctrl: RTL and testbench
===================================

# frecomp_rot_ctrl

Sequencer for the frequency-compensation phase-rotation accumulator in the 802.11 OFDM receiver. It accepts one frequency-offset estimate per packet and issues the accumulator's load/accumulate/enable strobes. It then steps the accumulator once per accepted time-domain sample across a programmed number of 80-sample OFDM symbols (16 CP plus 64 FFT), flags symbol and cyclic-prefix boundaries for downstream CP removal, and returns to idle on completion or abort.

## Interface
- NFFT, 64, FFT samples per symbol
- NCP, 16, cyclic-prefix samples per symbol
- SYMW, 8, width of the symbol-count input and counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- fo_vld  in  1  frequency-offset estimate strobe, single cycle
- fo_est  in  16  offset estimate, signed 3.13, sampled when fo_vld=1
- init_phase  in  16  starting rotation phase, signed 3.13, sampled with fo_est
- nsym  in  SYMW  symbols in packet, sampled with fo_est; 0 = reject
- smp_vld  in  1  one input sample present this cycle
- abort  in  1  terminate the current packet
- rot_ld  out  1  accumulator load strobe
- rot_acc  out  1  accumulator accumulate enable
- rot_ce  out  1  accumulator clock enable
- rot_phase_ld  out  16  registered copy of init_phase
- rot_phase_in  out  16  registered copy of fo_est
- sym_start  out  1  current accepted sample is index 0 of a symbol
- cp_flag  out  1  current accepted sample lies in CP (index < NCP)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last sample of the last symbol
- fo_drop  out  1  one-cycle pulse when fo_vld is ignored

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: when fo_vld=1 and nsym≠0, register fo_est→rot_phase_in, init_phase→rot_phase_ld, and nsym→sym_tot; clear smp_idx (0..NFFT+NCP−1) and sym_idx; go to LOAD.
- IDLE with fo_vld=1 and nsym=0: pulse fo_drop and stay in IDLE.
- LOAD, exactly one cycle: rot_ld=1, rot_ce=1, rot_acc=0; go to RUN. Any smp_vld in this cycle is not counted. The upstream pipeline does not present samples until busy has been high for 2 cycles.
- RUN: rot_acc=1 and rot_ce=smp_vld, both combinational. On each smp_vld:
  - increment smp_idx;
  - when smp_idx = NFFT+NCP−1, wrap it to 0 and increment sym_idx;
  - when the wrapped sample is the last one (sym_idx = sym_tot−1), go to IDLE and pulse done next cycle.
- sym_start = smp_vld & RUN & (smp_idx=0). cp_flag = smp_vld & RUN & (smp_idx<NCP). Both are combinational.
- fo_vld in LOAD or RUN: ignored, fo_drop pulses, and latched values are unchanged.
- abort in LOAD or RUN: go to IDLE next cycle, no done pulse, and rot_ce/rot_acc/rot_ld forced to 0 in that cycle. abort has priority over smp_vld and over the last-sample transition.
- abort in IDLE: no effect. An abort together with fo_vld in IDLE still starts the packet.

## Timing
- Reset values: state IDLE, all 1-bit outputs 0, rot_phase_ld=0, rot_phase_in=0, counters 0.
- fo_vld at cycle t: LOAD at t+1 (rot_ld=rot_ce=1, busy=1), RUN from t+2.
- One rot_ce pulse per accepted sample, with zero cycles of latency from smp_vld. The accumulator's phase output for sample k is valid the cycle after its rot_ce.
- Last sample accepted at cycle t: state is IDLE at t+1 with done=1 and busy=0. A new fo_vld at t+1 is accepted.
- Gaps in smp_vld are allowed; counters hold.
- A packet takes exactly nsym·(NFFT+NCP) rot_ce pulses after the load pulse.

## Test plan
- Nominal packet: fo_est=16'h0100, init_phase=0, nsym=2, smp_vld continuous from RUN.
  - Expect 1 rot_ld pulse and 160 rot_ce pulses with rot_acc=1.
  - Expect sym_start on samples 0 and 80, cp_flag on samples 0–15 and 80–95.
  - Expect done 1 cycle after sample 159 and busy low on that cycle.
- Gapped input: nsym=1, smp_vld toggling 1/0.
  - Expect exactly 80 rot_ce pulses, each coincident with smp_vld.
  - Expect done after the 80th accepted sample.
- Rejects: fo_vld with nsym=0 in IDLE gives fo_drop=1 and busy stays 0. A second fo_vld during RUN gives fo_drop=1 and rot_phase_in unchanged.
- Abort: abort at accepted sample 37 of nsym=3.
  - Expect IDLE next cycle, no done, and no rot_ce in the abort cycle.
  - A following fo_vld restarts with smp_idx=0.
- Back-to-back packets: fo_vld on the done cycle is accepted and rot_ld pulses the next cycle.
- Reset mid-RUN: all outputs return to reset values on the next cycle and no done is produced.

Source files
------------

// File: rtl/frecomp_rot_ctrl.sv
// Phase-rotation accumulator sequencer: loads a per-packet frequency offset, then
// steps the accumulator once per accepted sample over nsym 80-sample OFDM symbols.
module frecomp_rot_ctrl #(
  parameter int NFFT = 64,
  parameter int NCP  = 16,
  parameter int SYMW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fo_vld,
  input  logic [15:0]     fo_est,
  input  logic [15:0]     init_phase,
  input  logic [SYMW-1:0] nsym,
  input  logic            smp_vld,
  input  logic            abort,
  output logic            rot_ld,
  output logic            rot_acc,
  output logic            rot_ce,
  output logic [15:0]     rot_phase_ld,
  output logic [15:0]     rot_phase_in,
  output logic            sym_start,
  output logic            cp_flag,
  output logic            busy,
  output logic            done,
  output logic            fo_drop
);

  localparam int SPS  = NFFT + NCP;
  localparam int SMPW = $clog2(SPS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t          r_state;
  logic [SMPW-1:0] r_smp_idx;
  logic [SYMW-1:0] r_sym_idx;
  logic [SYMW-1:0] r_sym_tot;
  logic [15:0]     r_phase_ld;
  logic [15:0]     r_phase_in;
  logic            r_done;

  logic w_idle;
  logic w_load;
  logic w_run;
  logic w_smp_last;
  logic w_sym_last;
  logic w_accept;

  assign w_idle     = (r_state == S_IDLE);
  assign w_load     = (r_state == S_LOAD);
  assign w_run      = (r_state == S_RUN);
  assign w_smp_last = (r_smp_idx == SMPW'(SPS - 1));
  assign w_sym_last = (r_sym_idx == (r_sym_tot - SYMW'(1)));
  // abort suppresses every accumulator strobe in the cycle it is seen
  assign w_accept   = w_run & smp_vld & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_smp_idx  <= '0;
      r_sym_idx  <= '0;
      r_sym_tot  <= '0;
      r_phase_ld <= '0;
      r_phase_in <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fo_vld && (nsym != '0)) begin
            r_phase_in <= fo_est;
            r_phase_ld <= init_phase;
            r_sym_tot  <= nsym;
            r_smp_idx  <= '0;
            r_sym_idx  <= '0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (smp_vld) begin
            if (w_smp_last) begin
              r_smp_idx <= '0;
              if (w_sym_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_sym_idx <= r_sym_idx + SYMW'(1);
              end
            end else begin
              r_smp_idx <= r_smp_idx + SMPW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rot_ld       = w_load & ~abort;
  assign rot_acc      = w_run & ~abort;
  assign rot_ce       = (w_load & ~abort) | w_accept;
  assign rot_phase_ld = r_phase_ld;
  assign rot_phase_in = r_phase_in;
  assign sym_start    = smp_vld & w_run & (r_smp_idx == '0);
  assign cp_flag      = smp_vld & w_run & (r_smp_idx < SMPW'(NCP));
  assign busy         = ~w_idle;
  assign done         = r_done;
  assign fo_drop      = fo_vld & (~w_idle | (nsym == '0));

endmodule

// File: tb/tb_frecomp_rot_ctrl.sv
// Scenario bench for frecomp_rot_ctrl: per-sample boundary flags are predicted into a
// scoreboard queue when a sample is driven and popped when the DUT issues rot_ce.
module tb_frecomp_rot_ctrl;

  localparam int NFFT = 64;
  localparam int NCP  = 16;
  localparam int SYMW = 8;
  localparam int SPS  = NFFT + NCP;

  logic            clk = 1'b0;
  logic            rst;
  logic            fo_vld;
  logic [15:0]     fo_est;
  logic [15:0]     init_phase;
  logic [SYMW-1:0] nsym;
  logic            smp_vld;
  logic            abort;
  logic            rot_ld;
  logic            rot_acc;
  logic            rot_ce;
  logic [15:0]     rot_phase_ld;
  logic [15:0]     rot_phase_in;
  logic            sym_start;
  logic            cp_flag;
  logic            busy;
  logic            done;
  logic            fo_drop;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic ss;
    logic cp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  frecomp_rot_ctrl #(.NFFT(NFFT), .NCP(NCP), .SYMW(SYMW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fo_vld       (fo_vld),
    .fo_est       (fo_est),
    .init_phase   (init_phase),
    .nsym         (nsym),
    .smp_vld      (smp_vld),
    .abort        (abort),
    .rot_ld       (rot_ld),
    .rot_acc      (rot_acc),
    .rot_ce       (rot_ce),
    .rot_phase_ld (rot_phase_ld),
    .rot_phase_in (rot_phase_in),
    .sym_start    (sym_start),
    .cp_flag      (cp_flag),
    .busy         (busy),
    .done         (done),
    .fo_drop      (fo_drop)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet from the fo_vld cycle through its final sample (or abort);
  // returns at the start of the cycle following the last accepted/aborted sample.
  task automatic drive_packet(input logic [15:0] fo, input logic [15:0] ph,
                              input logic [SYMW-1:0] n, input bit gapped,
                              input int abort_at, input bit expect_done,
                              output int n_ce, output int n_ld);
    int total;
    int k;
    int cyc;
    bit v;
    bit ab;
    bit aborted;
    exp_t e;
    n_ce = 0;
    n_ld = 0;
    total = int'(n) * SPS;
    k = 0;
    cyc = 0;
    aborted = 1'b0;
    fo_vld = 1'b1; fo_est = fo; init_phase = ph; nsym = n; smp_vld = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (fo_drop !== 1'b0) begin errors++; $display("FAIL accept_fo_drop: got %b want 0", fo_drop); end
    checks++;
    if (done !== expect_done) begin errors++; $display("FAIL accept_done: got %b want %b", done, expect_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy: got %b want 0", busy); end
    next_cycle();
    fo_vld = 1'b0; fo_est = ~fo; init_phase = ~ph;
    @(negedge clk);
    if (rot_ld === 1'b1) n_ld++;
    checks++;
    if ({rot_ld, rot_ce, rot_acc, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL load_strobes: got ld/ce/acc/busy=%b%b%b%b want 1101", rot_ld, rot_ce, rot_acc, busy);
    end
    checks++;
    if (rot_phase_in !== fo || rot_phase_ld !== ph) begin
      errors++;
      $display("FAIL load_phase: got in=%h ld=%h want in=%h ld=%h", rot_phase_in, rot_phase_ld, fo, ph);
    end
    next_cycle();
    while (k < total && cyc < total * 2 + 10) begin
      v = gapped ? (cyc % 2 == 0) : 1'b1;
      ab = v && (k == abort_at);
      smp_vld = v;
      abort = ab;
      if (v && !ab) begin
        e.ss = (k % SPS == 0);
        e.cp = (k % SPS < NCP);
        sb.push_back(e);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rot_ld !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_status k=%0d: got busy/ld/done=%b%b%b want 100", k, busy, rot_ld, done);
      end
      checks++;
      if (rot_acc !== !ab) begin errors++; $display("FAIL run_acc k=%0d: got %b want %b", k, rot_acc, !ab); end
      checks++;
      if (rot_ce !== (v && !ab)) begin errors++; $display("FAIL run_ce k=%0d: got %b want %b", k, rot_ce, v && !ab); end
      if (rot_ce === 1'b1) begin
        n_ce++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow k=%0d: got rot_ce=1 want no pulse", k);
        end else begin
          e = sb.pop_front();
          if (sym_start !== e.ss || cp_flag !== e.cp) begin
            errors++;
            $display("FAIL flags k=%0d: got ss/cp=%b%b want %b%b", k, sym_start, cp_flag, e.ss, e.cp);
          end
        end
      end
      next_cycle();
      cyc++;
      if (ab) begin
        aborted = 1'b1;
        break;
      end
      if (v) k++;
    end
    smp_vld = 1'b0;
    abort = 1'b0;
    checks++;
    if (!aborted && k < total) begin errors++; $display("FAIL run_timeout: got %0d samples want %0d", k, total); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    sb.delete();
    $display("packet fo=%h ph=%h nsym=%0d gapped=%0d ld=%0d ce=%0d aborted=%0d", fo, ph, n, gapped, n_ld, n_ce, aborted);
  endtask

  task automatic test_reset();
    rst = 1'b1; fo_vld = 1'b0; fo_est = '0; init_phase = '0; nsym = '0; smp_vld = 1'b0; abort = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({rot_ld, rot_acc, rot_ce, sym_start, cp_flag, busy, done, fo_drop} !== 8'h00 ||
        rot_phase_ld !== 16'h0 || rot_phase_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got bits=%b ld=%h in=%h want all 0", {rot_ld, rot_acc, rot_ce, sym_start, cp_flag, busy, done, fo_drop}, rot_phase_ld, rot_phase_in);
    end
    rst = 1'b0;
    next_cycle();
    $display("reset released");
  endtask

  task automatic test_nominal();
    int ce;
    int ld;
    drive_packet(16'h0100, 16'h0000, 8'd2, 1'b0, -1, 1'b0, ce, ld);
    checks++;
    if (ce != 2 * SPS) begin errors++; $display("FAIL nominal_ce_count: got %0d want %0d", ce, 2 * SPS); end
    checks++;
    if (ld != 1) begin errors++; $display("FAIL nominal_ld_count: got %0d want 1", ld); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rot_ce !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done: got done/busy/ce=%b%b%b want 100", done, busy, rot_ce);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL nominal_done_pulse: got %b want 0", done); end
    next_cycle();
  endtask

  task automatic test_gapped();
    int ce;
    int ld;
    drive_packet(16'hF3A0, 16'h2000, 8'd1, 1'b1, -1, 1'b0, ce, ld);
    checks++;
    if (ce != SPS) begin errors++; $display("FAIL gapped_ce_count: got %0d want %0d", ce, SPS); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL gapped_done: got done/busy=%b%b want 10", done, busy); end
    next_cycle();
  endtask

  task automatic test_rejects();
    fo_vld = 1'b1; fo_est = 16'h1111; init_phase = 16'h2222; nsym = '0;
    @(negedge clk);
    checks++;
    if (fo_drop !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reject_nsym0: got drop/busy=%b%b want 10", fo_drop, busy); end
    next_cycle();
    fo_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rot_ld !== 1'b0 || fo_drop !== 1'b0) begin
      errors++;
      $display("FAIL reject_nsym0_after: got busy/ld/drop=%b%b%b want 000", busy, rot_ld, fo_drop);
    end
    next_cycle();
    fo_vld = 1'b1; fo_est = 16'h0ABC; init_phase = 16'h0DEF; nsym = 8'd4;
    next_cycle();
    fo_vld = 1'b0;
    next_cycle();
    fo_vld = 1'b1; fo_est = 16'h5555; init_phase = 16'h6666; nsym = 8'd9;
    @(negedge clk);
    checks++;
    if (fo_drop !== 1'b1) begin errors++; $display("FAIL reject_run_drop: got %b want 1", fo_drop); end
    next_cycle();
    fo_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (rot_phase_in !== 16'h0ABC || rot_phase_ld !== 16'h0DEF || busy !== 1'b1 || fo_drop !== 1'b0) begin
      errors++;
      $display("FAIL reject_run_hold: got in=%h ld=%h busy=%b drop=%b want 0abc 0def 1 0", rot_phase_in, rot_phase_ld, busy, fo_drop);
    end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reject_cleanup: got busy/done=%b%b want 00", busy, done); end
    next_cycle();
    $display("rejects exercised");
  endtask

  task automatic test_abort();
    int ce;
    int ld;
    drive_packet(16'h0040, 16'h0100, 8'd3, 1'b0, 37, 1'b0, ce, ld);
    checks++;
    if (ce != 37) begin errors++; $display("FAIL abort_ce_count: got %0d want 37", ce); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rot_ce !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy/done/ce=%b%b%b want 000", busy, done, rot_ce);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
    next_cycle();
    drive_packet(16'h0041, 16'h0101, 8'd1, 1'b0, -1, 1'b0, ce, ld);
    checks++;
    if (ce != SPS) begin errors++; $display("FAIL abort_restart_ce: got %0d want %0d", ce, SPS); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL abort_restart_done: got %b want 1", done); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int ce;
    int ld;
    drive_packet(16'h7000, 16'h0001, 8'd1, 1'b0, -1, 1'b0, ce, ld);
    drive_packet(16'h8001, 16'hFFFF, 8'd1, 1'b0, -1, 1'b1, ce, ld);
    checks++;
    if (ld != 1 || ce != SPS) begin errors++; $display("FAIL b2b_counts: got ld=%0d ce=%0d want 1 %0d", ld, ce, SPS); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done: got done/busy=%b%b want 10", done, busy); end
    next_cycle();
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    fo_vld = 1'b1; fo_est = 16'hABCD; init_phase = 16'h0123; nsym = 8'd2;
    next_cycle();
    fo_vld = 1'b0;
    next_cycle();
    smp_vld = 1'b1;
    repeat (10) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rot_ld, rot_acc, rot_ce, sym_start, cp_flag, busy, done, fo_drop} !== 8'h00 ||
        rot_phase_ld !== 16'h0 || rot_phase_in !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset: got bits=%b ld=%h in=%h want all 0", {rot_ld, rot_acc, rot_ce, sym_start, cp_flag, busy, done, fo_drop}, rot_phase_ld, rot_phase_in);
    end
    next_cycle();
    smp_vld = 1'b0;
    saw_done = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      next_cycle();
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midrun_no_done: got done/busy activity want none"); end
    $display("reset mid-run exercised");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_rejects();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
